fft_frame_sched: RTL and testbench

//  Frame scheduler sharing one 16-point FFT core (CTRL + IOBUF/FSC datapath) between N_REQ requesters.

---
 rtl/fft_sched_pkg.sv | 34 +++
 rtl/rr_arb.sv | 51 +++++
 rtl/fft_frame_sched.sv | 189 ++++++++++++++++++
 tb/tb_fft_frame_sched.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_sched_pkg.sv
// ---------------------------------------------------------------------------
// fft_sched_pkg
// Shared definitions for the FFT frame scheduler: FSM state encodings,
// default core timing constants and a small helper for sizing counters.
// ---------------------------------------------------------------------------
package fft_sched_pkg;

  // Scheduler states, one per phase of a core frame
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STRT  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_GAP   = 3'd5
  } sched_state_e;

  // Default timing of the shared 16-point FFT core
  localparam int DEF_IN_CYC  = 8;
  localparam int DEF_OUT_CYC = 8;
  localparam int DEF_GAP_CYC = 3;
  localparam int DEF_TMO_CYC = 64;

  // Largest of four values, used to size the shared phase counter
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arb
// Combinational round-robin picker. Returns the first asserted request at or
// after the pointer, wrapping around to index 0. The pointer register itself
// lives in the parent so it only advances when a frame is actually started.
// Ports:
//   req_i  [N_REQ-1:0]  request vector
//   ptr_i  [IDX_W-1:0]  highest-priority index for this pick
//   idx_o  [IDX_W-1:0]  winning index (0 when nothing is requested)
//   any_o               at least one request is asserted
// ---------------------------------------------------------------------------
module rr_arb
  import fft_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic             hiFound;
  logic [IDX_W-1:0] hiIdx;
  logic             loFound;
  logic [IDX_W-1:0] loIdx;

  // Scanning downward leaves the lowest matching index in each slot: hi* is
  // the lowest request at/after the pointer, lo* the lowest overall (used
  // only when the search has to wrap).
  always_comb begin
    hiFound = 1'b0;
    hiIdx   = '0;
    loFound = 1'b0;
    loIdx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        loFound = 1'b1;
        loIdx   = IDX_W'(i);
        if (i >= int'(ptr_i)) begin
          hiFound = 1'b1;
          hiIdx   = IDX_W'(i);
        end
      end
    end
    idx_o = hiFound ? hiIdx : loIdx;
    any_o = loFound;
  end

endmodule

// File: rtl/fft_frame_sched.sv
// ---------------------------------------------------------------------------
// fft_frame_sched
// Shares one 16-point FFT core between N_REQ requesters. Grants frames in
// round-robin order, pulses the core start, gates requester data through the
// input window, tags the core output window with its owner, holds off the
// next start for the core's post-output stall, and raises sticky fault flags.
// Ports:
//   CLK, RSTn        clock (rising edge), async active-low reset
//   REQ   [N_REQ]    per-requester frame request (level, held until GNT)
//   GNT   [N_REQ]    one-hot grant, STRT through last LOAD cycle
//   IN_SEL[IDX_W]    owner index for the input mux
//   IN_VALID, IN_IDX input window strobe and sample-pair index
//   CORE_START       one-cycle start pulse to the core
//   CORE_DONE        core output-window indicator
//   OUT_VALID,OUT_TAG qualified core output and its owner
//   BUSY             scheduler not idle
//   ERR_TMO,ERR_PROTO sticky fault flags, CLR_ERR clears (set wins)
// ---------------------------------------------------------------------------
module fft_frame_sched
  import fft_sched_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int IN_CYC  = DEF_IN_CYC,
  parameter int OUT_CYC = DEF_OUT_CYC,
  parameter int GAP_CYC = DEF_GAP_CYC,
  parameter int TMO_CYC = DEF_TMO_CYC
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [N_REQ-1:0] REQ,
  output logic [N_REQ-1:0] GNT,
  output logic [IDX_W-1:0] IN_SEL,
  output logic             IN_VALID,
  output logic [2:0]       IN_IDX,
  output logic             CORE_START,
  input  logic             CORE_DONE,
  output logic             OUT_VALID,
  output logic [IDX_W-1:0] OUT_TAG,
  output logic             BUSY,
  output logic             ERR_TMO,
  output logic             ERR_PROTO,
  input  logic             CLR_ERR
);

  localparam int CNT_MAX = max4(IN_CYC, OUT_CYC, TMO_CYC, GAP_CYC);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  sched_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] ptr_q;
  logic [N_REQ-1:0] gnt_q;
  logic             coreStart_q;
  logic             inValid_q;
  logic [2:0]       inIdx_q;
  logic             busy_q;
  logic             errTmo_q;
  logic             errProto_q;

  logic [IDX_W-1:0] winner_d;
  logic             reqAny_d;

  rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i (REQ),
    .ptr_i (ptr_q),
    .idx_o (winner_d),
    .any_o (reqAny_d)
  );

  // Main frame FSM. One counter is shared by every timed phase (input window,
  // timeout, output length, stall) since only one phase is ever active.
  // The error clear is written first so a same-cycle set overrides it.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      owner_q     <= '0;
      ptr_q       <= '0;
      gnt_q       <= '0;
      coreStart_q <= 1'b0;
      inValid_q   <= 1'b0;
      inIdx_q     <= '0;
      busy_q      <= 1'b0;
      errTmo_q    <= 1'b0;
      errProto_q  <= 1'b0;
    end else begin
      if (CLR_ERR) begin
        errTmo_q   <= 1'b0;
        errProto_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (CORE_DONE) errProto_q <= 1'b1;
          if (reqAny_d) begin
            owner_q     <= winner_d;
            gnt_q       <= N_REQ'(1) << winner_d;
            coreStart_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_STRT;
          end
        end
        ST_STRT: begin
          if (CORE_DONE) errProto_q <= 1'b1;
          ptr_q       <= (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
          coreStart_q <= 1'b0;
          inValid_q   <= 1'b1;
          inIdx_q     <= '0;
          cnt_q       <= '0;
          state_q     <= ST_LOAD;
        end
        ST_LOAD: begin
          if (CORE_DONE) errProto_q <= 1'b1;
          if (cnt_q == CNT_W'(IN_CYC - 1)) begin
            inValid_q <= 1'b0;
            inIdx_q   <= '0;
            gnt_q     <= '0;
            cnt_q     <= '0;
            state_q   <= ST_WAIT;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            inIdx_q <= inIdx_q + 3'd1;
          end
        end
        ST_WAIT: begin
          // The first DONE cycle is output cycle 0, so DRAIN starts at 1
          if (CORE_DONE) begin
            if (OUT_CYC == 1) begin
              cnt_q   <= '0;
              state_q <= ST_GAP;
            end else begin
              cnt_q   <= CNT_W'(1);
              state_q <= ST_DRAIN;
            end
          end else if (cnt_q == CNT_W'(TMO_CYC - 1)) begin
            errTmo_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ST_GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!CORE_DONE) begin
            errProto_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= ST_GAP;
          end else if (cnt_q == CNT_W'(OUT_CYC - 1)) begin
            cnt_q   <= '0;
            state_q <= ST_GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (CORE_DONE) errProto_q <= 1'b1;
          if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign GNT        = gnt_q;
  assign IN_SEL     = owner_q;
  assign IN_VALID   = inValid_q;
  assign IN_IDX     = inIdx_q;
  assign CORE_START = coreStart_q;
  assign OUT_TAG    = owner_q;
  assign BUSY       = busy_q;
  assign ERR_TMO    = errTmo_q;
  assign ERR_PROTO  = errProto_q;

  // Core output only counts while a frame is expecting it
  assign OUT_VALID = CORE_DONE && ((state_q == ST_WAIT) || (state_q == ST_DRAIN));

endmodule

// File: tb/tb_fft_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_sched
// Directed bench for the FFT frame scheduler: a table of round-robin picker
// vectors plus hand-written frame sequences against a simple core model.
// ---------------------------------------------------------------------------
module tb_fft_frame_sched;
  import fft_sched_pkg::*;

  logic       CLK;
  logic       RSTn;
  logic [1:0] REQ;
  logic       CLR_ERR;
  logic       coreDone;
  logic       manualDone;
  logic [1:0] GNT;
  logic       IN_SEL;
  logic       IN_VALID;
  logic [2:0] IN_IDX;
  logic       CORE_START;
  logic       OUT_VALID;
  logic       OUT_TAG;
  logic       BUSY;
  logic       ERR_TMO;
  logic       ERR_PROTO;

  logic [2:0] arbReq;
  logic [1:0] arbPtr;
  logic [1:0] arbIdx;
  logic       arbAny;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lastFall = -100;
  int   prevStart = -100;
  logic prevDone = 1'b0;
  int   coreIter = 4;
  int   coreLen = 8;
  logic coreNever = 1'b0;

  typedef struct {
    logic [2:0] req;
    logic [1:0] ptr;
    logic [1:0] expIdx;
    logic       expAny;
  } arbVec_t;

  arbVec_t vecs[10];

  logic [12:0] outsVec;
  assign outsVec = {GNT, IN_SEL, IN_VALID, IN_IDX, CORE_START, OUT_VALID,
                    OUT_TAG, BUSY, ERR_TMO, ERR_PROTO};

  fft_frame_sched #(
    .N_REQ (2),
    .IDX_W (1)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .REQ        (REQ),
    .GNT        (GNT),
    .IN_SEL     (IN_SEL),
    .IN_VALID   (IN_VALID),
    .IN_IDX     (IN_IDX),
    .CORE_START (CORE_START),
    .CORE_DONE  (coreDone | manualDone),
    .OUT_VALID  (OUT_VALID),
    .OUT_TAG    (OUT_TAG),
    .BUSY       (BUSY),
    .ERR_TMO    (ERR_TMO),
    .ERR_PROTO  (ERR_PROTO),
    .CLR_ERR    (CLR_ERR)
  );

  rr_arb #(
    .N_REQ (3),
    .IDX_W (2)
  ) arb3 (
    .req_i (arbReq),
    .ptr_i (arbPtr),
    .idx_o (arbIdx),
    .any_o (arbAny)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Remember the cycle in which DONE was first seen low again
  initial forever begin
    @(negedge CLK);
    if (prevDone && !(coreDone | manualDone)) lastFall = cyc;
    prevDone = coreDone | manualDone;
  end

  // Core model: after START, 8 input cycles plus coreIter compute cycles,
  // then DONE for coreLen cycles (or never, when coreNever is set)
  initial begin
    coreDone = 1'b0;
    forever begin
      @(negedge CLK);
      if (CORE_START) begin
        repeat (DEF_IN_CYC + coreIter) @(posedge CLK);
        #1;
        if (!coreNever) begin
          coreDone = 1'b1;
          repeat (coreLen) @(posedge CLK);
          #1;
          coreDone = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic applyStimulus(input arbVec_t v, input int n);
    arbReq = v.req;
    arbPtr = v.ptr;
    #1;
    checkOutput($sformatf("arb any vec%0d", n), arbAny, v.expAny);
    if (v.expAny) checkOutput($sformatf("arb idx vec%0d", n), arbIdx, v.expIdx);
  endtask

  task automatic waitStart(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!CORE_START && n < 400);
    checkOutput({nm, " start seen"}, CORE_START, 1);
  endtask

  // Observe one whole frame from START until BUSY falls
  task automatic runFrame(input logic [1:0] expGnt, input logic expTag, input int expOut,
                          input int expTail, input bit gapChk, input bit dropReq, input string nm);
    int n, gntCnt, inCnt, idxBad, outCnt, tagBad, startCnt, lastOut;
    gntCnt = 0; inCnt = 0; idxBad = 0; outCnt = 0; tagBad = 0; startCnt = 0; lastOut = cyc;
    waitStart(nm);
    if (!CORE_START) return;
    if (dropReq) REQ = 2'b00;
    checkOutput({nm, " gnt at start"}, GNT, expGnt);
    if (gapChk) begin
      checkOutput({nm, " start spacing"}, cyc - prevStart, 24);
      checkOutput({nm, " done-fall to start"}, cyc - lastFall, 4);
    end
    prevStart = cyc;
    n = 0;
    while (BUSY && n < 400) begin
      if (CORE_START) startCnt++;
      if (GNT == expGnt) gntCnt++;
      if (IN_VALID) begin
        if (IN_IDX != 3'(inCnt) || IN_SEL != expTag) idxBad++;
        inCnt++;
      end
      if (OUT_VALID) begin
        if (OUT_TAG != expTag) tagBad++;
        outCnt++;
        lastOut = cyc;
      end
      @(negedge CLK);
      n++;
    end
    checkOutput({nm, " busy falls"}, BUSY, 0);
    checkOutput({nm, " start pulses"}, startCnt, 1);
    checkOutput({nm, " gnt cycles"}, gntCnt, 9);
    checkOutput({nm, " in_valid cycles"}, inCnt, 8);
    checkOutput({nm, " in_idx/sel errors"}, idxBad, 0);
    checkOutput({nm, " out_valid cycles"}, outCnt, expOut);
    checkOutput({nm, " out_tag errors"}, tagBad, 0);
    checkOutput({nm, " tail to idle"}, cyc - lastOut, expTail);
  endtask

  initial begin
    int k;
    vecs[0] = '{3'b101, 2'd1, 2'd2, 1'b1};
    vecs[1] = '{3'b101, 2'd0, 2'd0, 1'b1};
    vecs[2] = '{3'b101, 2'd2, 2'd2, 1'b1};
    vecs[3] = '{3'b000, 2'd1, 2'd0, 1'b0};
    vecs[4] = '{3'b010, 2'd2, 2'd1, 1'b1};
    vecs[5] = '{3'b011, 2'd2, 2'd0, 1'b1};
    vecs[6] = '{3'b110, 2'd0, 2'd1, 1'b1};
    vecs[7] = '{3'b111, 2'd1, 2'd1, 1'b1};
    vecs[8] = '{3'b100, 2'd0, 2'd2, 1'b1};
    vecs[9] = '{3'b011, 2'd1, 2'd1, 1'b1};

    RSTn = 1'b0; REQ = 2'b00; CLR_ERR = 1'b0; manualDone = 1'b0;
    arbReq = 3'b000; arbPtr = 2'd0;
    repeat (3) @(negedge CLK);
    checkOutput("reset outputs", outsVec, 0);
    RSTn = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

    // Both requesters held: grants alternate starting from pointer 0
    REQ = 2'b11;
    runFrame(2'b01, 1'b0, 8, 4, 1'b0, 1'b0, "rr0");
    runFrame(2'b10, 1'b1, 8, 4, 1'b1, 1'b0, "rr1");
    runFrame(2'b01, 1'b0, 8, 4, 1'b1, 1'b0, "rr2");
    runFrame(2'b10, 1'b1, 8, 4, 1'b1, 1'b0, "rr3");
    REQ = 2'b00;
    repeat (2) @(negedge CLK);

    // Single requester 0
    REQ = 2'b01;
    runFrame(2'b01, 1'b0, 8, 4, 1'b0, 1'b1, "single");
    checkOutput("single no errors", {ERR_TMO, ERR_PROTO}, 0);

    // Core never answers: timeout fires after 64 WAIT cycles
    coreNever = 1'b1;
    REQ = 2'b01;
    waitStart("tmo");
    REQ = 2'b00;
    k = 0;
    while (!ERR_TMO && k < 200) begin
      @(negedge CLK);
      k++;
    end
    checkOutput("tmo latency from start", k, 73);
    k = 0;
    while (BUSY && k < 20) begin
      k++;
      @(negedge CLK);
    end
    checkOutput("tmo gap cycles", k, 3);
    repeat (2) @(negedge CLK);
    checkOutput("tmo sticky", ERR_TMO, 1);
    checkOutput("tmo no proto", ERR_PROTO, 0);
    CLR_ERR = 1'b1;
    @(negedge CLK);
    CLR_ERR = 1'b0;
    checkOutput("tmo cleared", ERR_TMO, 0);
    coreNever = 1'b0;

    // Short DONE window
    coreLen = 5;
    REQ = 2'b01;
    runFrame(2'b01, 1'b0, 5, 5, 1'b0, 1'b1, "proto");
    checkOutput("proto flag", ERR_PROTO, 1);
    checkOutput("proto no tmo", ERR_TMO, 0);
    coreLen = 8;
    REQ = 2'b10;
    runFrame(2'b10, 1'b1, 8, 4, 1'b0, 1'b1, "after proto");
    CLR_ERR = 1'b1;
    @(negedge CLK);
    CLR_ERR = 1'b0;
    checkOutput("proto cleared", ERR_PROTO, 0);

    // DONE in IDLE together with clear: the set wins, state stays idle
    manualDone = 1'b1;
    CLR_ERR = 1'b1;
    @(negedge CLK);
    manualDone = 1'b0;
    CLR_ERR = 1'b0;
    checkOutput("idle done set wins", ERR_PROTO, 1);
    checkOutput("idle done stays idle", BUSY, 0);

    // Reset in the middle of LOAD
    coreNever = 1'b1;
    REQ = 2'b10;
    waitStart("rst frame");
    REQ = 2'b00;
    k = 0;
    while (!(IN_VALID && IN_IDX == 3'd4) && k < 50) begin
      @(negedge CLK);
      k++;
    end
    checkOutput("reach load idx4", IN_IDX, 4);
    checkOutput("pre-reset tag", OUT_TAG, 1);
    RSTn = 1'b0;
    #1;
    checkOutput("mid-frame reset outputs", outsVec, 0);
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    REQ = 2'b10;
    waitStart("post reset");
    REQ = 2'b00;
    checkOutput("post reset gnt", GNT, 2'b10);
    checkOutput("post reset in_sel", IN_SEL, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
